// File: rtl/ram_serial_port.sv
// Serial-frame RAM access port: shifts in {op, addr, data}, executes a
// write (strobes held WR_CYCLES cycles) or a read (capture RAM_DOUT).
// Ports:
//   i_clk, i_rst_n (async, active low)
//   i_si, i_shift_en, i_update   serial frame in / execute request
//   o_so                         MSB of capture register
//   o_ram_read, o_ram_write      strobe level (1 = write access)
//   o_ram_addr, o_ram_din        latched address / write data
//   i_ram_dout                   RAM read data
//   o_busy, o_done, o_frame_err  status
// Option: define RAM_SP_PARITY_EN for a 16-bit frame with even parity.
module ram_serial_port #(
  parameter int WR_CYCLES = 2,
  parameter int RD_LAT    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_si,
  input  logic       i_shift_en,
  input  logic       i_update,
  output logic       o_so,
  output logic       o_ram_read,
  output logic       o_ram_write,
  output logic [5:0] o_ram_addr,
  output logic [7:0] o_ram_din,
  input  logic [7:0] i_ram_dout,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_frame_err
);

`ifdef RAM_SP_PARITY_EN
  localparam int FL = 16;
`else
  localparam int FL = 15;
`endif
  localparam logic [4:0] FL5 = 5'(FL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [FL-1:0] r_frame;
  logic [7:0]    r_cap;
  logic [4:0]    r_bits;
  logic [3:0]    r_cyc;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_par_ok;
  logic          w_len_ok;
  logic          w_accept;
  logic          w_reject;
  logic          w_cyc_last;
  logic          w_shift;

`ifdef RAM_SP_PARITY_EN
  assign w_par_ok = ~^r_frame;
`else
  assign w_par_ok = 1'b1;
`endif

  // Update is judged on the pre-shift counter and frame.
  assign w_len_ok = (r_bits == FL5);
  assign w_accept = !r_busy && i_update && w_len_ok && w_par_ok;
  assign w_reject = !r_busy && i_update && !(w_len_ok && w_par_ok);
  assign w_shift  = !r_busy && i_shift_en;

  assign w_cyc_last = (r_state == S_WRITE)
                    ? (r_cyc == 4'(WR_CYCLES - 1))
                    : (r_cyc == 4'(RD_LAT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = r_frame[FL-1] ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_cyc_last) begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        if (w_cyc_last) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame    <= '0;
      r_cap      <= '0;
      r_bits     <= '0;
      r_cyc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
    end else begin
      r_err  <= w_reject;
      r_done <= (r_state == S_WRITE && w_cyc_last)
             || (r_state == S_CAPTURE);
      // Per-state cycle counter restarts on every state change.
      r_cyc  <= (w_next != r_state) ? '0 : r_cyc + 4'd1;
      // Busy spans acceptance through the DONE cycle.
      if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_accept) begin
        r_busy <= 1'b1;
      end
      if (w_shift) begin
        r_frame <= {r_frame[FL-2:0], i_si};
        r_cap   <= {r_cap[6:0], 1'b0};
        if (r_bits != 5'd31) begin
          r_bits <= r_bits + 5'd1;
        end
      end
      if (w_accept || w_reject) begin
        r_bits <= '0;
      end
      if (w_accept) begin
        o_ram_addr <= r_frame[FL-2 -: 6];
        o_ram_din  <= r_frame[FL-8 -: 8];
      end
      if (r_state == S_CAPTURE) begin
        r_cap <= i_ram_dout;
      end
    end
  end

  assign o_ram_read  = (r_state == S_WRITE);
  assign o_ram_write = (r_state == S_WRITE);
  assign o_so        = r_cap[7];
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_err = r_err;

endmodule

// File: tb/tb_ram_serial_port.sv
// Bench for ram_serial_port: directed frame vectors plus
// same-cycle, busy-noise, parity and mid-access reset sequences.
module tb_ram_serial_port;

`ifdef RAM_SP_PARITY_EN
  localparam int FL = 16;
`else
  localparam int FL = 15;
`endif

  logic       clk;
  logic       rst_n;
  logic       si;
  logic       shift_en;
  logic       update;
  logic       so;
  logic       ram_read;
  logic       ram_write;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;
  logic       done;
  logic       frame_err;

  logic [7:0] mem [64];
  logic       preload;

  int checks;
  int errors;

  ram_serial_port dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_si        (si),
    .i_shift_en  (shift_en),
    .i_update    (update),
    .o_so        (so),
    .o_ram_read  (ram_read),
    .o_ram_write (ram_write),
    .o_ram_addr  (ram_addr),
    .o_ram_din   (ram_din),
    .i_ram_dout  (ram_dout),
    .o_busy      (busy),
    .o_done      (done),
    .o_frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[6'h2D] <= 8'h32;
    end else if (ram_write) begin
      mem[ram_addr] <= ram_din;
    end
  end

  assign ram_dout = mem[ram_addr];

  typedef struct {
    logic       op;
    logic [5:0] addr;
    logic [7:0] data;
    int         delta;
    logic       exp_err;
    int         exp_strb;
    int         exp_done_at;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic op,
      input logic [5:0] a, input logic [7:0] d, input logic bad_par);
    logic [14:0] f15;
    f15 = {op, a, d};
    if (FL == 16) return {f15, (^f15) ^ bad_par};
    return {1'b0, f15};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_frame(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      si = (i < FL) ? f[FL-1-i] : 1'b0;
      shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
    si = 1'b0;
  endtask

  task automatic do_update(input logic noise, output int strb,
      output int dones, output int errs, output int done_at,
      output logic busy0, output logic busy_end, output logic uneq);
    strb = 0; dones = 0; errs = 0; done_at = -1; uneq = 1'b0;
    update = 1'b1;
    step();
    update = 1'b0;
    busy0 = busy;
    for (int c = 0; c < 12; c++) begin
      strb  += int'(ram_read);
      errs  += int'(frame_err);
      if (ram_read != ram_write) uneq = 1'b1;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      shift_en = noise && busy;
      si       = noise && busy;
      update   = noise && busy && c[0];
      step();
    end
    shift_en = 1'b0;
    update   = 1'b0;
    si       = 1'b0;
    busy_end = busy;
  endtask

  task automatic read_so(output logic [7:0] v);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], so};
      shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
  endtask

  task automatic clear_cnt();
    update = 1'b1;
    step();
    update = 1'b0;
    step();
  endtask

  initial begin
    logic [15:0] f;
    int          strb;
    int          dones;
    int          errs;
    int          dat;
    logic        b0;
    logic        be;
    logic        ue;
    logic [7:0]  rd;
    logic [5:0]  exp_addr;
    logic [7:0]  exp_din;

    checks = 0;
    errors = 0;
    si = 0; shift_en = 0; update = 0;
    preload = 1'b1;
    rst_n = 1'b0;

    vecs[0] = '{1'b0, 6'h2D, 8'h00,  0,   1'b0, 0, 2, 8'h32};
    vecs[1] = '{1'b1, 6'h2D, 8'h32,  0,   1'b0, 2, 2, 8'h00};
    vecs[2] = '{1'b1, 6'h11, 8'h44, -1,   1'b1, 0, -1, 8'h00};
    vecs[3] = '{1'b1, 6'h05, 8'hA5,  1,   1'b1, 0, -1, 8'h00};
    vecs[4] = '{1'b1, 6'h05, 8'hA5,  0,   1'b0, 2, 2, 8'h00};
    vecs[5] = '{1'b0, 6'h05, 8'h5A,  0,   1'b0, 0, 2, 8'hA5};
    vecs[6] = '{1'b1, 6'h3F, 8'hFF,  0,   1'b0, 2, 2, 8'h00};
    vecs[7] = '{1'b0, 6'h3F, 8'h00,  0,   1'b0, 0, 2, 8'hFF};
    vecs[8] = '{1'b1, 6'h01, 8'h01, -FL,  1'b1, 0, -1, 8'h00};

    step();
    step();
    chk("reset_outputs",
        {so, ram_read, ram_write, ram_addr, ram_din, busy, done, frame_err},
        '0);
    preload = 1'b0;
    rst_n = 1'b1;
    step();

    exp_addr = 6'h00;
    exp_din  = 8'h00;
    foreach (vecs[k]) begin
      f = mk_frame(vecs[k].op, vecs[k].addr, vecs[k].data, 1'b0);
      shift_frame(f, FL + vecs[k].delta);
      do_update(1'b0, strb, dones, errs, dat, b0, be, ue);
      if (!vecs[k].exp_err) begin
        exp_addr = vecs[k].addr;
        exp_din  = vecs[k].data;
      end
      chk($sformatf("v%0d_err", k), errs, vecs[k].exp_err ? 1 : 0);
      chk($sformatf("v%0d_strobes", k), strb, vecs[k].exp_strb);
      chk($sformatf("v%0d_done_at", k), dat, vecs[k].exp_done_at);
      chk($sformatf("v%0d_busy", k), {b0, be}, {~vecs[k].exp_err, 1'b0});
      chk($sformatf("v%0d_addr_din", k), {ram_addr, ram_din},
          {exp_addr, exp_din});
      chk($sformatf("v%0d_strb_eq", k), ue, 1'b0);
      if (!vecs[k].exp_err && !vecs[k].op) begin
        read_so(rd);
        chk($sformatf("v%0d_so_data", k), rd, vecs[k].exp_rd);
        clear_cnt();
      end
    end
    chk("mem_3f", mem[6'h3F], 8'hFF);

    // UPDATE with the 15th shift judges the pre-shift count.
    f = mk_frame(1'b1, 6'h10, 8'h77, 1'b0);
    shift_frame(f, FL - 1);
    si = f[0];
    shift_en = 1'b1;
    update = 1'b1;
    step();
    shift_en = 1'b0;
    update = 1'b0;
    chk("same_cycle_err", {frame_err, busy}, 2'b10);
    step();
    shift_frame(f, FL);
    do_update(1'b0, strb, dones, errs, dat, b0, be, ue);
    chk("after_same_cycle_write", {strb, errs}, {32'd2, 32'd0});
    chk("mem_10", mem[6'h10], 8'h77);

    // Shift/update noise while busy must be ignored.
    f = mk_frame(1'b1, 6'h2A, 8'hC3, 1'b0);
    shift_frame(f, FL);
    do_update(1'b1, strb, dones, errs, dat, b0, be, ue);
    chk("noise_dones", dones, 1);
    chk("noise_errs", errs, 0);
    chk("noise_strobes", strb, 2);
    f = mk_frame(1'b0, 6'h2A, 8'h00, 1'b0);
    shift_frame(f, FL);
    do_update(1'b0, strb, dones, errs, dat, b0, be, ue);
    chk("noise_cnt_intact", {errs, dones}, {32'd0, 32'd1});
    read_so(rd);
    chk("noise_readback", rd, 8'hC3);
    clear_cnt();

`ifdef RAM_SP_PARITY_EN
    f = mk_frame(1'b1, 6'h21, 8'h3C, 1'b1);
    shift_frame(f, FL);
    do_update(1'b0, strb, dones, errs, dat, b0, be, ue);
    chk("bad_parity", {errs, strb, dones}, {32'd1, 32'd0, 32'd0});
    f = mk_frame(1'b1, 6'h21, 8'h3C, 1'b0);
    shift_frame(f, FL);
    do_update(1'b0, strb, dones, errs, dat, b0, be, ue);
    chk("good_parity", {errs, strb, dones}, {32'd0, 32'd2, 32'd1});
`endif

    // Reset in the second write cycle aborts the access.
    f = mk_frame(1'b1, 6'h33, 8'h99, 1'b0);
    shift_frame(f, FL);
    update = 1'b1;
    step();
    update = 1'b0;
    chk("rst_w1_strobe", ram_write, 1'b1);
    step();
    chk("rst_w2_strobe", ram_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_all_zero",
        {so, ram_read, ram_write, ram_addr, ram_din, busy, done, frame_err},
        '0);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      dones += int'(done) + int'(ram_write);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      dones += int'(done) + int'(ram_write);
    end
    chk("rst_no_done", dones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
